// File: rtl/pulse_cmd_dispatcher.sv
`default_nettype none
// ============================================================================
//  Module      : pulse_cmd_dispatcher
//  Description : Queues event pulses as a pending count, dispatches one
//                command per event over a valid/ready start interface and
//                tracks each command to done or timeout.
//  Revision    : 1.0 - initial release
// ============================================================================
module pulse_cmd_dispatcher #(
   parameter int          MAX_PENDING    = 4,
   parameter logic [31:0] TIMEOUT_CYCLES = 32'd0,
   parameter int          CNT_WIDTH      = 16,
   localparam int         PEND_W         = $clog2(MAX_PENDING + 1)
) (
   input  logic                 clk,
   input  logic                 reset_n,
   input  logic                 i_pulse,
   output logic                 o_ready,
   output logic                 o_start_valid,
   input  logic                 i_start_ready,
   input  logic                 i_done,
   input  logic                 i_clear,
   output logic                 o_busy,
   output logic [PEND_W-1:0]    o_pending,
   output logic [CNT_WIDTH-1:0] o_completed,
   output logic                 o_overflow,
   output logic                 o_timeout
);

   localparam logic [1:0]        c_IDLE     = 2'd0;
   localparam logic [1:0]        c_REQ      = 2'd1;
   localparam logic [1:0]        c_BUSY     = 2'd2;
   localparam logic [PEND_W-1:0] c_MAX_PEND = PEND_W'(MAX_PENDING);
   localparam logic              c_TO_EN    = (TIMEOUT_CYCLES != 32'd0);
   localparam logic [31:0]       c_TO_LAST  = TIMEOUT_CYCLES - 32'd1;

   logic [1:0]           state_q,     state_d;
   logic [PEND_W-1:0]    pending_q,   pending_d;
   logic [CNT_WIDTH-1:0] completed_q, completed_d;
   logic [31:0]          timer_q,     timer_d;
   logic                 overflow_q,  overflow_d;
   logic                 timeout_q,   timeout_d;

   logic w_ready;
   logic w_dequeue;
   logic w_accept;
   logic w_drop;
   logic w_abort;

   assign w_ready   = (pending_q < c_MAX_PEND);
   assign w_dequeue = (state_q == c_IDLE) && (pending_q != '0);
   // A dequeue in the same cycle frees a slot, so a pulse arriving at a full
   // queue is still absorbed and the queue stays full.
   assign w_accept  = i_pulse && (w_ready || w_dequeue);
   assign w_drop    = i_pulse && !w_accept;

   // Next-state logic for the command FSM, timer and completion counter
   always_comb begin
      state_d     = state_q;
      timer_d     = timer_q;
      completed_d = completed_q;
      w_abort     = 1'b0;
      case (state_q)
         c_IDLE: begin
            if (w_dequeue) begin
               state_d = c_REQ;
            end
         end
         c_REQ: begin
            if (i_start_ready) begin
               state_d = c_BUSY;
               timer_d = 32'd0;
            end
         end
         c_BUSY: begin
            timer_d = timer_q + 32'd1;
            if (i_done) begin
               state_d     = c_IDLE;
               completed_d = completed_q + CNT_WIDTH'(1);
            end else if (c_TO_EN && (timer_q == c_TO_LAST)) begin
               state_d = c_IDLE;
               w_abort = 1'b1;
            end
         end
         default: begin
            state_d = c_IDLE;
         end
      endcase
   end

   // Pending count: simultaneous enqueue and dequeue cancel out
   always_comb begin
      pending_d = pending_q;
      case ({w_accept, w_dequeue})
         2'b10:   pending_d = pending_q + PEND_W'(1);
         2'b01:   pending_d = pending_q - PEND_W'(1);
         default: pending_d = pending_q;
      endcase
   end

   // Sticky flags: a new set event outranks a coincident clear
   always_comb begin
      overflow_d = overflow_q;
      timeout_d  = timeout_q;
      if (w_drop) begin
         overflow_d = 1'b1;
      end else if (i_clear) begin
         overflow_d = 1'b0;
      end
      if (w_abort) begin
         timeout_d = 1'b1;
      end else if (i_clear) begin
         timeout_d = 1'b0;
      end
   end

   // State registers with asynchronous clear
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         state_q     <= c_IDLE;
         pending_q   <= '0;
         completed_q <= '0;
         timer_q     <= 32'd0;
         overflow_q  <= 1'b0;
         timeout_q   <= 1'b0;
      end else begin
         state_q     <= state_d;
         pending_q   <= pending_d;
         completed_q <= completed_d;
         timer_q     <= timer_d;
         overflow_q  <= overflow_d;
         timeout_q   <= timeout_d;
      end
   end

   assign o_ready       = w_ready;
   assign o_start_valid = (state_q == c_REQ);
   assign o_busy        = (state_q != c_IDLE);
   assign o_pending     = pending_q;
   assign o_completed   = completed_q;
   assign o_overflow    = overflow_q;
   assign o_timeout     = timeout_q;

endmodule
`default_nettype wire
